bcd_scan_driver: RTL
====================

# bcd_scan_driver

Upstream feeder for the calculator's seven-segment digit decoder. Accepts a binary result over a valid/ready handshake, converts it to four BCD digits with a sequential double-dabble, applies leading-zero blanking, and time-multiplexes the digits onto one shared 4-bit digit bus plus a one-hot digit-select. The decoder turns the digit bus into segments; codes above 9 drive a blank digit.

## Interface
- NUM_DIGITS, 4, digits scanned; fixed at 4 for this revision.
- SCAN_DIV, 50000, clock cycles per digit slot; must be ≥1.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  value is presented.
- in_value  in  14  unsigned binary value, 0..16383.
- in_ready  out  1  high when a new value can be accepted.
- digit  out  4  BCD code for the selected digit; 4'hF means blank.
- digit_sel  out  4  one-hot active-high select; bit 0 is the least significant digit.
- busy  out  1  a conversion is in progress.
- overflow  out  1  the last accepted value exceeded 9999.

## Operation
- FSM states: IDLE, CONVERT.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - value ≤ 9999: load the shift register; bit counter=0; go to CONVERT.
  - value > 9999: commit all four display digits = 4'hF and set overflow=1 on the same edge; stay in IDLE.
- CONVERT: in_ready=0; busy=1; in_valid is ignored.
  - Each cycle performs one double-dabble step. First, add 3 to every BCD nibble ≥5. Then shift left by 1.
  - After the 14th step, commit the display registers, clear overflow, and return to IDLE.
- Commit uses leading-zero blanking. Any digit above the most significant nonzero digit gets 4'hF. Digit 0 is never blanked, so value 0 displays "0".
- Display registers update only at commit. The old contents stay on the display during CONVERT.
- Scan divider:
  - Counts 0..SCAN_DIV-1. On wrap, the slot index advances 0→1→2→3→0.
  - It runs continuously and is independent of the FSM.
  - SCAN_DIV=1 advances the slot every cycle.
- digit_sel = one-hot(slot index). digit = display register[slot index]. Both are combinational from registers, with no extra latency.
- Reset (asynchronous, any time, including mid-CONVERT) forces:
  - state IDLE, in_ready=1, busy=0, overflow=0;
  - all display registers 4'hF;
  - slot index 0, so digit_sel=4'b0001 and digit=4'hF;
  - scan counter 0.
- A partial conversion is discarded on reset.

## Timing
- Accept edge E0 (in-range value): busy high after E0. Steps occur at E1..E14. Commit and the return to IDLE happen at E14, so in_ready is high after E14.
- Latency: 14 cycles from accept to new display contents. Throughput: one value per 15 cycles with in_valid held.
- Overflow path: commit happens at E0. in_ready stays high, so back-to-back accepts are allowed.
- A commit coinciding with a slot advance takes effect together. The new slot shows the new digit in the same cycle.
- in_value is sampled only at the accept edge. Later changes have no effect.

## Structure
- Package calc_display_pkg holds:
  - NUM_DIGITS;
  - BLANK_CODE = 4'hF;
  - MAX_VALUE = 9999;
  - VALUE_W = 14;
  - the FSM enum (IDLE, CONVERT).
- Sub-module bin2bcd_seq implements the shift register, add-3 step, and bit counter. Its interface is start/value in, done/bcd[15:0] out.
- The top level holds the handshake, blanking/commit logic, display registers, and scan divider.

## Test plan
- Reset with no input: digit_sel=4'b0001, digit=4'hF, in_ready=1, busy=0, overflow=0. With SCAN_DIV=4, digit_sel rotates 0001→0010→0100→1000→0001 every 4 cycles.
- Accept 1234: busy for exactly 14 cycles, then digits 4,3,2,1 on slots 0..3. in_ready must not rise before commit.
- Accept 7: slots show 7,F,F,F. Accept 0: slots show 0,F,F,F. Accept 9999: slots show 9,9,9,9.
- Accept 10000: overflow=1 on the next cycle, all slots F, no busy cycles. Then accept 42: overflow clears at commit, slots show 2,4,F,F.
- Pulse in_valid with value 555 mid-CONVERT of 1234: the pulse is ignored and the display shows 1234.
- Assert rst_n low at step 7 of converting 8888: all outputs return to reset values immediately. After release, accept 31 and display 1,3,F,F.

Source files
------------

// File: rtl/calc_display_pkg.sv
// Shared constants, FSM encoding and the leading-zero blanking helper for the
// calculator display path.
package calc_display_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned VALUE_W    = 14;
   localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
   localparam int unsigned SLOT_W     = $clog2(NUM_DIGITS);

   localparam logic [3:0]         BLANK_CODE = 4'hF;
   localparam logic [VALUE_W-1:0] MAX_VALUE  = 14'd9999;

   typedef enum logic {
      IDLE,
      CONVERT
   } state_t;

   // Blank every digit above the most significant nonzero one; digit 0 always shows.
   function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      logic             lead;
      res  = bcd;
      lead = 1'b1;
      for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (lead && (bcd[4*i +: 4] == 4'd0)) begin
            res[4*i +: 4] = BLANK_CODE;
         end else begin
            lead = 1'b0;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per cycle, VALUE_W steps per value.
// done and bcd present the outcome of the step being taken in the current cycle.
module bin2bcd_seq
   import calc_display_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [VALUE_W-1:0] value,
   output logic               done,
   output logic [BCD_W-1:0]   bcd
);

   localparam int unsigned SR_W = BCD_W + VALUE_W;

   logic [SR_W-1:0] sr;
   logic [SR_W-1:0] adj;
   logic [SR_W-1:0] stepped;
   logic [3:0]      cnt;
   logic            active;

   always_comb begin
      adj = sr;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (adj[VALUE_W + 4*i +: 4] >= 4'd5) begin
            adj[VALUE_W + 4*i +: 4] = adj[VALUE_W + 4*i +: 4] + 4'd3;
         end
      end
      stepped = {adj[SR_W-2:0], 1'b0};
   end

   assign done = active && (cnt == 4'(VALUE_W - 1));
   assign bcd  = stepped[SR_W-1 -: BCD_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr     <= '0;
         cnt    <= '0;
         active <= 1'b0;
      end else if (start) begin
         sr     <= {{BCD_W{1'b0}}, value};
         cnt    <= '0;
         active <= 1'b1;
      end else if (active) begin
         sr  <= stepped;
         cnt <= cnt + 4'd1;
         if (done) begin
            active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/bcd_scan_driver.sv
// Accepts a binary value, converts it to blanked BCD and time-multiplexes the
// four digits onto a shared digit bus with a one-hot select.
module bcd_scan_driver
   import calc_display_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [VALUE_W-1:0]    in_value,
   output logic                  in_ready,
   output logic [3:0]            digit,
   output logic [NUM_DIGITS-1:0] digit_sel,
   output logic                  busy,
   output logic                  overflow
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   state_t                       state;
   state_t                       state_next;
   logic                         start;
   logic                         commit_ovf;
   logic                         commit_bcd;
   logic                         conv_done;
   logic [BCD_W-1:0]             conv_bcd;
   logic [NUM_DIGITS-1:0][3:0]   disp;
   logic [CNT_W-1:0]             scan_cnt;
   logic [SLOT_W-1:0]            slot;

   bin2bcd_seq u_conv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .value (in_value),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = 1'b0;
      start      = 1'b0;
      commit_ovf = 1'b0;
      commit_bcd = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_value > MAX_VALUE) begin
                  commit_ovf = 1'b1;
               end else begin
                  start      = 1'b1;
                  state_next = CONVERT;
               end
            end
         end
         CONVERT: begin
            busy = 1'b1;
            if (conv_done) begin
               commit_bcd = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp     <= {NUM_DIGITS{BLANK_CODE}};
         overflow <= 1'b0;
      end else if (commit_ovf) begin
         disp     <= {NUM_DIGITS{BLANK_CODE}};
         overflow <= 1'b1;
      end else if (commit_bcd) begin
         disp     <= blank_leading(conv_bcd);
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         slot     <= '0;
      end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         slot     <= slot + 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   always_comb begin
      digit_sel       = '0;
      digit_sel[slot] = 1'b1;
      digit           = disp[slot];
   end

endmodule
